exu_wbck_arb: RTL and testbench

EXU_WBCK_ARB -- requirements
Module: exu_wbck_arb

---
 rtl/exu_wbck_arb.sv | 128 ++++++++++++
 tb/tb_exu_wbck_arb.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/exu_wbck_arb.sv
// Write-back arbiter: merges ALU and long-pipe write-back requests into a
// single registered regfile write port. The long pipe wins by default; an ALU
// request that has stalled STARVE_LIMIT cycles is given one turn of priority.
module exu_wbck_arb #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned RFIDX_WIDTH  = 5,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,

    input  logic                   alu_wbck_i_valid,
    output logic                   alu_wbck_i_ready,
    input  logic [XLEN-1:0]        alu_wbck_i_data,
    input  logic [RFIDX_WIDTH-1:0] alu_wbck_i_rdidx,

    input  logic                   longp_wbck_i_valid,
    output logic                   longp_wbck_i_ready,
    input  logic [XLEN-1:0]        longp_wbck_i_data,
    input  logic [RFIDX_WIDTH-1:0] longp_wbck_i_rdidx,

    output logic                   rf_wbck_o_ena,
    output logic [XLEN-1:0]        rf_wbck_o_data,
    output logic [RFIDX_WIDTH-1:0] rf_wbck_o_rdidx,

    output logic                   arb_alu_pri
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic {
        LONGP_PRI = 1'b0,
        ALU_PRI   = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ena_q, ena_d;
    logic [XLEN-1:0]        data_q, data_d;
    logic [RFIDX_WIDTH-1:0] rdidx_q, rdidx_d;

    logic                   alu_hs;
    logic                   longp_hs;
    logic [CNT_W-1:0]       cnt_inc;

    // Grant, starve counter, FSM next state and write-port next values
    always_comb begin
        state_d            = state_q;
        cnt_d              = cnt_q;
        ena_d              = 1'b0;
        data_d             = data_q;
        rdidx_d            = rdidx_q;
        alu_wbck_i_ready   = 1'b0;
        longp_wbck_i_ready = 1'b0;
        cnt_inc            = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);

        if (state_q == ALU_PRI) begin
            alu_wbck_i_ready   = alu_wbck_i_valid;
            longp_wbck_i_ready = longp_wbck_i_valid & ~alu_wbck_i_valid;
        end else begin
            longp_wbck_i_ready = longp_wbck_i_valid;
            alu_wbck_i_ready   = alu_wbck_i_valid & ~longp_wbck_i_valid;
        end

        alu_hs   = alu_wbck_i_valid & alu_wbck_i_ready;
        longp_hs = longp_wbck_i_valid & longp_wbck_i_ready;

        if (alu_hs) begin
            cnt_d = '0;
        end else if (alu_wbck_i_valid) begin
            cnt_d = cnt_inc;
        end

        unique case (state_q)
            LONGP_PRI: begin
                if (alu_wbck_i_valid && !alu_hs && (cnt_inc == CNT_LIMIT)) begin
                    state_d = ALU_PRI;
                end
            end
            ALU_PRI: begin
                // One ALU turn only; a withdrawn request also forfeits the turn
                // and restarts starvation counting from zero.
                if (alu_hs) begin
                    state_d = LONGP_PRI;
                end else if (!alu_wbck_i_valid) begin
                    state_d = LONGP_PRI;
                    cnt_d   = '0;
                end
            end
            default: state_d = LONGP_PRI;
        endcase

        if (alu_hs) begin
            ena_d   = (alu_wbck_i_rdidx != '0);
            data_d  = alu_wbck_i_data;
            rdidx_d = alu_wbck_i_rdidx;
        end else if (longp_hs) begin
            ena_d   = (longp_wbck_i_rdidx != '0);
            data_d  = longp_wbck_i_data;
            rdidx_d = longp_wbck_i_rdidx;
        end
    end

    // State, counter and registered write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LONGP_PRI;
            cnt_q   <= '0;
            ena_q   <= 1'b0;
            data_q  <= '0;
            rdidx_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ena_q   <= ena_d;
            data_q  <= data_d;
            rdidx_q <= rdidx_d;
        end
    end

    assign rf_wbck_o_ena   = ena_q;
    assign rf_wbck_o_data  = data_q;
    assign rf_wbck_o_rdidx = rdidx_q;
    assign arb_alu_pri     = (state_q == ALU_PRI);

endmodule

// File: tb/tb_exu_wbck_arb.sv
// Bench for exu_wbck_arb: directed vector table, starvation/reset sequences
// and randomized traffic against a behavioural priority/scoreboard model.
module tb_exu_wbck_arb;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned RW    = 5;
    localparam int unsigned LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          av, lv;
    logic          ar, lr;
    logic [XLEN-1:0] ad, ld;
    logic [RW-1:0]   ai, li;
    logic          ena;
    logic [XLEN-1:0] wdata;
    logic [RW-1:0]   widx;
    logic          pri;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    exu_wbck_arb #(
        .XLEN(XLEN), .RFIDX_WIDTH(RW), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .alu_wbck_i_valid   (av),
        .alu_wbck_i_ready   (ar),
        .alu_wbck_i_data    (ad),
        .alu_wbck_i_rdidx   (ai),
        .longp_wbck_i_valid (lv),
        .longp_wbck_i_ready (lr),
        .longp_wbck_i_data  (ld),
        .longp_wbck_i_rdidx (li),
        .rf_wbck_o_ena      (ena),
        .rf_wbck_o_data     (wdata),
        .rf_wbck_o_rdidx    (widx),
        .arb_alu_pri        (pri)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic a_v, input logic [XLEN-1:0] a_d, input logic [RW-1:0] a_i,
                         input logic l_v, input logic [XLEN-1:0] l_d, input logic [RW-1:0] l_i);
        av = a_v; ad = a_d; ai = a_i;
        lv = l_v; ld = l_d; li = l_i;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic          a_v;
        logic [XLEN-1:0] a_d;
        logic [RW-1:0]   a_i;
        logic          l_v;
        logic [XLEN-1:0] l_d;
        logic [RW-1:0]   l_i;
        logic          e_ar;
        logic          e_lr;
        logic          e_ena;
        logic [XLEN-1:0] e_data;
        logic [RW-1:0]   e_idx;
    } vec_t;

    vec_t vecs[6];

    // Behavioural model state for the random section
    int            starve;
    bit            alu_turn;
    bit            a_pend, l_pend;
    logic [XLEN-1:0] a_dat, l_dat, m_data;
    logic [RW-1:0]   a_idx, l_idx, m_idx;
    bit            g_alu, g_lp, m_ena;
    int            granted, cyc;

    initial begin
        rst_n = 1'b0;
        drive(1'b0, '0, '0, 1'b0, '0, '0);

        vecs[0] = '{1'b1, 32'h11, 5'd3, 1'b0, 32'h0,  5'd0, 1'b1, 1'b0, 1'b1, 32'h11, 5'd3};
        vecs[1] = '{1'b1, 32'hBB, 5'd6, 1'b1, 32'hAA, 5'd5, 1'b0, 1'b1, 1'b1, 32'hAA, 5'd5};
        vecs[2] = '{1'b0, 32'h0,  5'd0, 1'b1, 32'hFF, 5'd0, 1'b0, 1'b1, 1'b0, 32'hFF, 5'd0};
        vecs[3] = '{1'b0, 32'h0,  5'd0, 1'b0, 32'h0,  5'd0, 1'b0, 1'b0, 1'b0, 32'hFF, 5'd0};
        vecs[4] = '{1'b1, 32'h22, 5'd7, 1'b0, 32'h0,  5'd0, 1'b1, 1'b0, 1'b1, 32'h22, 5'd7};
        vecs[5] = '{1'b1, 32'hCC, 5'd0, 1'b0, 32'h0,  5'd0, 1'b1, 1'b0, 1'b0, 32'hCC, 5'd0};

        // Reset state
        #2;
        check("rst_ena", 64'(ena), 64'd0);
        check("rst_data", 64'(wdata), 64'd0);
        check("rst_idx", 64'(widx), 64'd0);
        check("rst_pri", 64'(pri), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed vector table
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(vecs[i].a_v, vecs[i].a_d, vecs[i].a_i, vecs[i].l_v, vecs[i].l_d, vecs[i].l_i);
            #1;
            check($sformatf("vec%0d_alu_ready", i), 64'(ar), 64'(vecs[i].e_ar));
            check($sformatf("vec%0d_longp_ready", i), 64'(lr), 64'(vecs[i].e_lr));
            @(posedge clk); #1;
            check($sformatf("vec%0d_ena", i), 64'(ena), 64'(vecs[i].e_ena));
            check($sformatf("vec%0d_data", i), 64'(wdata), 64'(vecs[i].e_data));
            check($sformatf("vec%0d_idx", i), 64'(widx), 64'(vecs[i].e_idx));
        end

        // Starvation: ALU held against continuous long-pipe traffic
        do_reset();
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) @(negedge clk);
            drive(1'b1, 32'hBB, 5'd6, 1'b1, 32'hA0 + 32'(c), 5'd5);
            #1;
            check($sformatf("starve%0d_pri", c), 64'(pri), 64'(c == 5));
            check($sformatf("starve%0d_alu_ready", c), 64'(ar), 64'(c == 5));
            check($sformatf("starve%0d_longp_ready", c), 64'(lr), 64'(c != 5));
            @(posedge clk); #1;
            check($sformatf("starve%0d_data", c), 64'(wdata), (c == 5) ? 64'hBB : 64'(32'hA0 + 32'(c)));
        end

        // Reset after an ALU handshake, with a request pending during reset
        do_reset();
        @(negedge clk);
        drive(1'b1, 32'h33, 5'd9, 1'b0, '0, '0);
        @(posedge clk); #1;
        check("rstseq_ena_before", 64'(ena), 64'd1);
        @(negedge clk);
        drive(1'b1, 32'h44, 5'd10, 1'b0, '0, '0);
        rst_n = 1'b0;
        #1;
        check("rstseq_ena_async", 64'(ena), 64'd0);
        check("rstseq_data_async", 64'(wdata), 64'd0);
        check("rstseq_idx_async", 64'(widx), 64'd0);
        @(posedge clk); #1;
        check("rstseq_ena_held", 64'(ena), 64'd0);
        @(negedge clk);
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rstseq_ena_after", 64'(ena), 64'd0);
        check("rstseq_data_after", 64'(wdata), 64'd0);

        // Random traffic against the reference model
        do_reset();
        starve = 0; alu_turn = 0;
        a_pend = 0; l_pend = 0;
        m_data = '0; m_idx = '0;
        granted = 0; cyc = 0;
        while (granted < 1000 && cyc < 20000) begin
            cyc++;
            @(negedge clk);
            if (!a_pend && $urandom_range(0, 3) != 0) begin
                a_pend = 1; a_dat = $urandom;
                a_idx = ($urandom_range(0, 7) == 0) ? '0 : RW'($urandom_range(0, 31));
            end else if (a_pend && $urandom_range(0, 15) == 0) begin
                a_pend = 0;
            end
            if (!l_pend && $urandom_range(0, 3) != 0) begin
                l_pend = 1; l_dat = $urandom;
                l_idx = ($urandom_range(0, 7) == 0) ? '0 : RW'($urandom_range(0, 31));
            end
            drive(a_pend, a_dat, a_idx, l_pend, l_dat, l_idx);
            #1;
            g_alu = a_pend && (alu_turn || !l_pend);
            g_lp  = l_pend && !g_alu;
            check("rand_pri", 64'(pri), 64'(alu_turn));
            check("rand_alu_ready", 64'(ar), 64'(g_alu));
            check("rand_longp_ready", 64'(lr), 64'(g_lp));
            check("rand_both_ready", 64'(ar & lr), 64'd0);
            m_ena = 0;
            if (g_alu) begin
                m_data = a_dat; m_idx = a_idx; m_ena = (a_idx != 0);
                a_pend = 0; granted++;
                starve = 0; alu_turn = 0;
            end else begin
                if (g_lp) begin
                    m_data = l_dat; m_idx = l_idx; m_ena = (l_idx != 0);
                    l_pend = 0; granted++;
                end
                if (a_pend) begin
                    starve = (starve < 15) ? starve + 1 : 15;
                    if (!alu_turn && starve == int'(LIMIT)) alu_turn = 1;
                end else if (alu_turn) begin
                    alu_turn = 0; starve = 0;
                end
            end
            @(posedge clk); #1;
            check("rand_ena", 64'(ena), 64'(m_ena));
            check("rand_data", 64'(wdata), 64'(m_data));
            check("rand_idx", 64'(widx), 64'(m_idx));
        end
        check("rand_completed", 64'(granted >= 1000), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
